// File: rtl/des_block_writer_pkg.sv
// des_writer_pkg: shared types and constants for the DES block writer.
//   state_e     - writer FSM states
//   WORD_STEP   - byte distance between the high and low word of a block
//   BLOCK_STEP  - byte distance between consecutive blocks
//   block_t     - one 64-bit encrypted block as delivered by the core
package des_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        WR_HI,
        WR_LO,
        FINISH
    } state_e;

    localparam int unsigned WORD_STEP  = 4;
    localparam int unsigned BLOCK_STEP = 8;

    typedef logic [63:0] block_t;

endpackage

// File: rtl/des_block_writer_if.sv
// des_block_writer_if: Avalon-MM write-master bundle.
//   master_address     - byte address            (master -> slave)
//   master_writedata   - write data              (master -> slave)
//   master_write       - write request           (master -> slave)
//   master_waitrequest - stall, holds the request (slave -> master)
interface des_block_writer_if #(
    parameter int unsigned AW = 26,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] master_address;
    logic [DW-1:0] master_writedata;
    logic          master_write;
    logic          master_waitrequest;

    modport master (
        output master_address,
        output master_writedata,
        output master_write,
        input  master_waitrequest
    );

    modport slave (
        input  master_address,
        input  master_writedata,
        input  master_write,
        output master_waitrequest
    );
endinterface

// File: rtl/des_block_writer_fifo.sv
// sync_fifo: single-clock FIFO holding encrypted blocks.
//   clk, reset - clock, synchronous active-high reset
//   flush      - empties the FIFO; a push in the same cycle lands as the sole entry
//   push, pop  - write / read strobes; pop on empty is ignored
//   wr_data    - entry to write
//   rd_data    - head entry (valid while !empty)
//   full/empty/count - occupancy status
// A push while full is accepted only when a pop frees a slot in the same cycle.
// A push and pop on an empty FIFO is not bypassed: the pop sees nothing.
module sync_fifo
    import des_writer_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(block_t),
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_pop, do_push, we;
    logic [AW-1:0]    wa;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign count   = cnt_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop);
    // During a flush the surviving push is written to slot 0.
    assign we      = flush ? push : do_push;
    assign wa      = flush ? '0 : wr_ptr_q;

    always_ff @(posedge clk) begin
        if (we && !reset)
            mem_q[wa] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= push ? AW'(1) : '0;
            cnt_q    <= push ? (AW+1)'(1) : '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)
                cnt_q <= cnt_q + (AW+1)'(1);
            else if (!do_push && do_pop)
                cnt_q <= cnt_q - (AW+1)'(1);
        end
    end
endmodule

// File: rtl/des_block_writer.sv
// des_block_writer: buffers 64-bit encrypted blocks and writes each one to memory
// as two Avalon-MM writes, high word at the block address, low word at +4.
//   clk, reset        - clock, synchronous active-high reset
//   start             - arms a transfer from IDLE, sampling base_address/block_count
//   base_address      - byte address of the first block
//   block_count       - number of blocks in the transfer (0 finishes immediately)
//   in_data, in_valid - block strobe from the core, no backpressure
//   av                - Avalon write master (address/writedata/write/waitrequest)
//   busy              - FSM not in IDLE
//   done              - one-cycle pulse after the final low word is accepted
//   blocks_written    - blocks completed since the last start
//   overflow          - sticky: a block was dropped (FIFO full, or arrived while IDLE)
module des_block_writer
    import des_writer_pkg::*;
#(
    parameter int unsigned MASTER_ADDRESSWIDTH = 26,
    parameter int unsigned DATAWIDTH           = 32,
    parameter int unsigned FIFO_DEPTH          = 8,
    parameter int unsigned FIFO_AW             = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [MASTER_ADDRESSWIDTH-1:0] base_address,
    input  logic [31:0]                    block_count,
    input  logic [2*DATAWIDTH-1:0]         in_data,
    input  logic                           in_valid,
    des_block_writer_if.master             av,
    output logic                           busy,
    output logic                           done,
    output logic [31:0]                    blocks_written,
    output logic                           overflow
);
    localparam int unsigned AW = MASTER_ADDRESSWIDTH;
    localparam int unsigned DW = DATAWIDTH;

    state_e          state_q, state_d;
    logic [AW-1:0]   cur_addr_q, cur_addr_d;
    logic [31:0]     count_q, count_d;
    logic [31:0]     bw_q, bw_d;
    logic [DW-1:0]   hold_q, hold_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            write_q, write_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;

    logic            fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty, drop;
    logic [2*DW-1:0] fifo_rd;
    logic [FIFO_AW:0] fifo_level;

    assign fifo_flush = (state_q == IDLE) && start;
    assign fifo_pop   = (state_q == WAIT_DATA) && !fifo_empty;
    // A start in the same cycle as in_valid keeps the block for the new transfer.
    assign fifo_push  = in_valid && ((state_q != IDLE) || start);
    assign drop       = in_valid &&
                        (((state_q == IDLE) && !start) ||
                         ((state_q != IDLE) && fifo_full && !fifo_pop));

    sync_fifo #(
        .WIDTH (2*DW),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (in_data),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_level)
    );

    // Master outputs are loaded one state ahead so they are registered and hold
    // steady while waitrequest is asserted.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        count_d    = count_q;
        bw_d       = bw_q;
        hold_d     = hold_q;
        addr_d     = addr_q;
        data_d     = data_q;
        write_d    = write_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d = base_address;
                    count_d    = block_count;
                    bw_d       = '0;
                    ovf_d      = 1'b0;
                    state_d    = (block_count == '0) ? FINISH : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (fifo_pop) begin
                    hold_d  = fifo_rd[DW-1:0];
                    addr_d  = cur_addr_q;
                    data_d  = fifo_rd[2*DW-1:DW];
                    write_d = 1'b1;
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                if (!av.master_waitrequest) begin
                    addr_d  = cur_addr_q + AW'(WORD_STEP);
                    data_d  = hold_q;
                    state_d = WR_LO;
                end
            end
            WR_LO: begin
                if (!av.master_waitrequest) begin
                    write_d    = 1'b0;
                    cur_addr_d = cur_addr_q + AW'(BLOCK_STEP);
                    bw_d       = bw_q + 32'd1;
                    state_d    = (bw_q + 32'd1 == count_q) ? FINISH : WAIT_DATA;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (drop)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            count_q    <= '0;
            bw_q       <= '0;
            hold_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            write_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            count_q    <= count_d;
            bw_q       <= bw_d;
            hold_q     <= hold_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            write_q    <= write_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            assert (fifo_level <= (FIFO_AW+1)'(FIFO_DEPTH));
    end

    assign av.master_address   = addr_q;
    assign av.master_writedata = data_q;
    assign av.master_write     = write_q;

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign blocks_written = bw_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_des_block_writer.sv
// tb_des_block_writer: directed stimulus with a beat scoreboard. Stimulus pushes the
// expected (address, data) beats; a negedge monitor pops one per accepted write.
module tb_des_block_writer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [25:0] base_address = '0;
    logic [31:0] block_count = '0;
    logic [63:0] in_data = '0;
    logic        busy, done, overflow;
    logic [31:0] blocks_written;

    des_block_writer_if #(.AW(26), .DW(32)) bus ();

    des_block_writer #(
        .MASTER_ADDRESSWIDTH (26),
        .DATAWIDTH           (32),
        .FIFO_DEPTH          (8),
        .FIFO_AW             (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_address   (base_address),
        .block_count    (block_count),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .av             (bus),
        .busy           (busy),
        .done           (done),
        .blocks_written (blocks_written),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [25:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          beat_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [25:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    // Monitor: inputs change at posedge+2, so negedge sees what the next edge samples.
    always @(negedge clk) begin
        beat_t e;
        if (prev_stall) begin
            checks++;
            if (!(bus.master_write === 1'b1 && bus.master_address === prev_addr &&
                  bus.master_writedata === prev_data)) begin
                errors++;
                $display("FAIL stall_hold: got write=%0b addr=0x%0h data=0x%0h required write=1 addr=0x%0h data=0x%0h",
                         bus.master_write, bus.master_address, bus.master_writedata, prev_addr, prev_data);
            end
        end
        prev_stall = !reset && (bus.master_write === 1'b1) && (bus.master_waitrequest === 1'b1);
        prev_addr  = bus.master_address;
        prev_data  = bus.master_writedata;

        if (!reset && bus.master_write === 1'b1 && bus.master_waitrequest === 1'b0) begin
            beat_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got addr=0x%0h data=0x%0h required no write",
                         bus.master_address, bus.master_writedata);
            end else begin
                e = exp_q.pop_front();
                if (bus.master_address !== e.addr || bus.master_writedata !== e.data) begin
                    errors++;
                    $display("FAIL beat: got addr=0x%0h data=0x%0h required addr=0x%0h data=0x%0h",
                             bus.master_address, bus.master_writedata, e.addr, e.data);
                end
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_block(input logic [25:0] a, input logic [63:0] b);
        beat_t t;
        t.addr = a;
        t.data = b[63:32];
        exp_q.push_back(t);
        t.addr = a + 26'd4;
        t.data = b[31:0];
        exp_q.push_back(t);
    endtask

    task automatic do_start(input logic [25:0] base, input logic [31:0] cnt);
        start        = 1'b1;
        base_address = base;
        block_count  = cnt;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [63:0] b);
        in_data  = b;
        in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_write(input string name, input int budget);
        for (int i = 0; i < budget && bus.master_write !== 1'b1; i++) cyc(1);
        chk(name, 64'(bus.master_write), 64'd1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) cyc(1);
        chk(name, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0, b0;
        bus.master_waitrequest = 1'b0;

        // Reset values
        cyc(3);
        reset = 1'b0;
        chk("rst_write", 64'(bus.master_write), 64'd0);
        chk("rst_addr", 64'(bus.master_address), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bw", 64'(blocks_written), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // in_valid while IDLE is dropped and flagged
        send(64'h5555_5555_5555_5555);
        chk("idle_drop_ovf", 64'(overflow), 64'd1);

        // Reset held 3 cycles while stalled in WR_HI abandons the write
        bus.master_waitrequest = 1'b1;
        do_start(26'h200, 32'd1);
        chk("start_clears_ovf", 64'(overflow), 64'd0);
        send(64'hAAAA_BBBB_CCCC_DDDD);
        wait_write("t1_write_up", 10);
        cyc(2);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        chk("t1_write_low", 64'(bus.master_write), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_ovf", 64'(overflow), 64'd0);
        chk("t1_no_done", 64'(done_cnt), 64'd0);
        bus.master_waitrequest = 1'b0;
        cyc(1);

        // Single block, no stall; in_valid at t -> write at t+2
        expect_block(26'h100, 64'h0123_4567_89AB_CDEF);
        do_start(26'h100, 32'd1);
        send(64'h0123_4567_89AB_CDEF);
        chk("t2_lat_t1", 64'(bus.master_write), 64'd0);
        cyc(1);
        chk("t2_lat_t2", 64'(bus.master_write), 64'd1);
        wait_done("t2_done", 30);
        chk("t2_bw", 64'(blocks_written), 64'd1);
        chk("t2_busy", 64'(busy), 64'd0);
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // Five stalled cycles in WR_HI; exactly two beats
        b0 = beat_cnt;
        bus.master_waitrequest = 1'b1;
        expect_block(26'h300, 64'hDEAD_BEEF_CAFE_F00D);
        do_start(26'h300, 32'd1);
        send(64'hDEAD_BEEF_CAFE_F00D);
        wait_write("t3_write_up", 10);
        cyc(5);
        bus.master_waitrequest = 1'b0;
        wait_done("t3_done", 30);
        chk("t3_beats", 64'(beat_cnt - b0), 64'd2);
        chk("t3_bw", 64'(blocks_written), 64'd1);

        // Overflow: block 0 goes to the hold register and stalls in WR_HI,
        // blocks 1..8 fill the FIFO, block 9 is dropped.
        d0 = done_cnt;
        bus.master_waitrequest = 1'b1;
        do_start(26'h1000, 32'd16);
        for (int i = 0; i < 9; i++)
            expect_block(26'h1000 + 26'(8 * i), {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)});
        for (int i = 0; i < 10; i++)
            send({32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)});
        chk("t4_ovf", 64'(overflow), 64'd1);
        chk("t4_bw_stalled", 64'(blocks_written), 64'd0);
        bus.master_waitrequest = 1'b0;
        for (int i = 0; i < 200 && blocks_written != 32'd9; i++) cyc(1);
        cyc(3);
        chk("t4_bw", 64'(blocks_written), 64'd9);
        chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_q_empty", 64'(exp_q.size()), 64'd0);
        chk("t4_ovf_sticky", 64'(overflow), 64'd1);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;

        // Address wrap, with first block arriving in the start cycle
        expect_block(26'h3FF_FFF8, 64'h1111_2222_3333_4444);
        expect_block(26'h000_0000, 64'h5555_6666_7777_8888);
        start        = 1'b1;
        base_address = 26'h3FF_FFF8;
        block_count  = 32'd2;
        in_data      = 64'h1111_2222_3333_4444;
        in_valid     = 1'b1;
        cyc(1);
        start    = 1'b0;
        in_valid = 1'b0;
        send(64'h5555_6666_7777_8888);
        wait_done("t5_done", 60);
        chk("t5_bw", 64'(blocks_written), 64'd2);
        chk("t5_ovf", 64'(overflow), 64'd0);
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

        // count == 0: done two cycles after start, no writes
        b0 = beat_cnt;
        do_start(26'h40, 32'd0);
        chk("t6_done_early", 64'(done), 64'd0);
        chk("t6_busy", 64'(busy), 64'd1);
        cyc(1);
        chk("t6_done", 64'(done), 64'd1);
        cyc(1);
        chk("t6_done_pulse", 64'(done), 64'd0);
        chk("t6_no_beats", 64'(beat_cnt - b0), 64'd0);
        chk("t6_bw", 64'(blocks_written), 64'd0);

        cyc(2);
        chk("final_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
